// File: rtl/vga_line_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// vga_fetch_pkg
// Shared types and helpers for the VGA line fetcher.
//   fetch_state_t : burst sequencer states (IDLE, REQ, WAIT_DATA)
//   fifo_aw()     : FIFO pointer index width for a given depth
//   burst_cw()    : burst word-counter width for a given burst length
//   Def*          : default configuration, also used to derive the widths below
// ---------------------------------------------------------------------------
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2
    } fetch_state_t;

    localparam int unsigned DefWordLength    = 16;
    localparam int unsigned DefAddressWidth  = 24;
    localparam int unsigned DefBurstLength   = 8;
    localparam int unsigned DefFifoDepth     = 32;
    localparam int unsigned DefFrameBase     = 0;
    localparam int unsigned DefFrameWords    = 307200;
    localparam int unsigned DefTimeoutCycles = 64;

    function automatic int unsigned fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the counter can hold the full burst length.
    function automatic int unsigned burst_cw(input int unsigned len);
        return $clog2(len) + 1;
    endfunction

    localparam int unsigned FifoAw   = fifo_aw(DefFifoDepth);
    localparam int unsigned BurstCw  = burst_cw(DefBurstLength);
    localparam int unsigned FrameEnd = DefFrameBase + DefFrameWords;

endpackage

// File: rtl/vga_line_fetcher_if.sv
// ---------------------------------------------------------------------------
// vga_line_fetcher_if
// Read-request bus between the line fetcher and the SDRAM controller.
//   enable   : one-cycle burst request (fetcher -> controller)
//   rw       : 1 = read (fetcher -> controller)
//   addr     : burst start word address, stable while enable is high
//   busy     : controller cannot accept a request (controller -> fetcher)
//   valid_rd : read word valid this cycle (controller -> fetcher)
//   data     : read word (controller -> fetcher)
// Modports: master = fetcher side, slave = controller side.
// ---------------------------------------------------------------------------
interface vga_line_fetcher_if #(
    parameter int unsigned WordLength   = 16,
    parameter int unsigned AddressWidth = 24
);
    logic                    enable;
    logic                    rw;
    logic [AddressWidth-1:0] addr;
    logic                    busy;
    logic                    valid_rd;
    logic [WordLength-1:0]   data;

    modport master (
        output enable, rw, addr,
        input  busy, valid_rd, data
    );

    modport slave (
        input  enable, rw, addr,
        output busy, valid_rd, data
    );
endinterface

// File: rtl/vga_line_fetcher_line_fifo.sv
// ---------------------------------------------------------------------------
// line_fifo
// Synchronous show-ahead FIFO with flush and write-pointer snapshot/rollback.
//   clk, rst     : clock, synchronous active-high reset
//   push, push_data : write one word
//   pop          : consume the head word (ignored while empty)
//   flush        : drop all contents (overrides push/pop/rollback)
//   snap         : remember the current write pointer
//   rollback     : discard every word written since the last snap
//   head, valid  : head word (zero while empty) and not-empty flag
//   count        : words held
// ---------------------------------------------------------------------------
module line_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       snap,
    input  logic                       rollback,
    output logic [Width-1:0]           head,
    output logic                       valid,
    output logic [$clog2(Depth):0]     count
);
    localparam int unsigned Aw = $clog2(Depth);

    logic [Width-1:0] storage [Depth];
    logic [Aw:0]      wr_ptr;
    logic [Aw:0]      rd_ptr;
    logic [Aw:0]      snap_wr;
    logic             do_pop;
    logic [Aw:0]      rd_after_pop;
    logic [Aw:0]      pushed_since;
    logic [Aw:0]      left_after_pop;
    logic [Aw:0]      rollback_wr;

    assign count  = wr_ptr - rd_ptr;
    assign valid  = (wr_ptr != rd_ptr);
    assign head   = valid ? storage[rd_ptr[Aw-1:0]] : '0;
    assign do_pop = pop && valid;

    assign rd_after_pop   = rd_ptr + {{Aw{1'b0}}, do_pop};
    assign pushed_since   = wr_ptr - snap_wr;
    assign left_after_pop = wr_ptr - rd_after_pop;
    // If the reader already consumed part of the discarded words, those are
    // gone; the FIFO just ends up empty instead of pointing behind the reader.
    assign rollback_wr    = (left_after_pop >= pushed_since) ? snap_wr : rd_after_pop;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every register regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            snap_wr <= '0;
        end else begin
            if (snap) begin
                snap_wr <= wr_ptr;
            end
            // Flush only moves the read pointer, so a snapshot taken before
            // or at the same edge stays meaningful.
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (rollback) begin
                    wr_ptr <= rollback_wr;
                end else if (push) begin
                    wr_ptr <= wr_ptr + {{Aw{1'b0}}, 1'b1};
                end
                rd_ptr <= rd_after_pop;
            end
        end
    end

    // NOTE: the storage array has no reset; empty is tracked by the pointers and
    // head is forced to zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wr_ptr[Aw-1:0]] <= push_data;
        end
    end

    // The fetcher only requests a burst when a whole burst fits.
    always_ff @(posedge clk) begin
        if (!rst && push && !flush) begin
            assert (count != (Aw+1)'(Depth) || do_pop);
        end
    end

endmodule

// File: rtl/vga_line_fetcher.sv
// ---------------------------------------------------------------------------
// vga_line_fetcher
// Streams the frame buffer out of SDRAM as back-to-back read bursts into a
// show-ahead FIFO feeding the VGA pixel path. A burst is requested only when
// the FIFO can take all of it, so read data is never dropped.
//   CLK, RST      : clock, synchronous active-high reset
//   i_run         : fetching allowed while high
//   i_frame_start : pulse; flush FIFO and restart at FrameBase
//   i_pix_ready   : consumer pops the head word this cycle
//   o_pix_data    : FIFO head word
//   o_pix_valid   : FIFO not empty
//   o_underflow   : sticky; pop attempted while empty and running
//   o_timeout     : sticky; burst aborted by the watchdog
//   mem           : controller read-request bus (master side)
// ---------------------------------------------------------------------------
module vga_line_fetcher
    import vga_fetch_pkg::*;
#(
    parameter int unsigned WordLength    = DefWordLength,
    parameter int unsigned AddressWidth  = DefAddressWidth,
    parameter int unsigned BurstLength   = DefBurstLength,
    parameter int unsigned FifoDepth     = DefFifoDepth,
    parameter int unsigned FrameBase     = DefFrameBase,
    parameter int unsigned FrameWords    = DefFrameWords,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_run,
    input  logic                  i_frame_start,
    input  logic                  i_pix_ready,
    output logic [WordLength-1:0] o_pix_data,
    output logic                  o_pix_valid,
    output logic                  o_underflow,
    output logic                  o_timeout,
    vga_line_fetcher_if.master    mem
);
    localparam int unsigned CntW = fifo_aw(FifoDepth) + 1;
    localparam int unsigned WcW  = burst_cw(BurstLength);
    localparam int unsigned WdW  = $clog2(TimeoutCycles + 1);

    localparam logic [AddressWidth-1:0] BaseAddr = AddressWidth'(FrameBase);
    localparam logic [AddressWidth-1:0] EndAddr  = AddressWidth'(FrameBase + FrameWords);

    fetch_state_t            state;
    fetch_state_t            state_next;
    logic [AddressWidth-1:0] fetch_addr;
    logic [AddressWidth-1:0] next_addr;
    logic [AddressWidth-1:0] wrapped_addr;
    logic [WcW-1:0]          word_cnt;
    logic [WdW-1:0]          wd_cnt;
    logic                    restart_pending;
    logic                    pending_next;
    logic                    mem_enable_q;
    logic [AddressWidth-1:0] mem_addr_q;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_flush;
    logic                    fifo_snap;
    logic                    fifo_rollback;
    logic [CntW-1:0]         fifo_count;

    logic                    space_ok;
    logic                    discard;
    logic                    last_word;
    logic                    wd_expired;
    logic                    addr_advance;
    logic                    timeout_hit;

    assign mem.enable = mem_enable_q;
    assign mem.addr   = mem_addr_q;
    assign mem.rw     = 1'b1;

    assign fifo_pop     = i_pix_ready && o_pix_valid;
    assign space_ok     = (CntW'(FifoDepth) - fifo_count) >= CntW'(BurstLength);
    // Words of a burst that straddles a frame restart belong to the old frame.
    assign discard      = restart_pending || i_frame_start;
    assign last_word    = mem.valid_rd && (word_cnt == WcW'(BurstLength - 1));
    assign wd_expired   = !mem.valid_rd && (wd_cnt == WdW'(TimeoutCycles - 1));
    assign next_addr    = fetch_addr + AddressWidth'(BurstLength);
    assign wrapped_addr = (next_addr == EndAddr) ? BaseAddr : next_addr;

    line_fifo #(
        .Width (WordLength),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (mem.data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .snap      (fifo_snap),
        .rollback  (fifo_rollback),
        .head      (o_pix_data),
        .valid     (o_pix_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        pending_next  = restart_pending;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        fifo_snap     = 1'b0;
        fifo_rollback = 1'b0;
        addr_advance  = 1'b0;
        timeout_hit   = 1'b0;

        case (state)
            IDLE: begin
                pending_next = 1'b0;
                if (i_frame_start) begin
                    fifo_flush = 1'b1;
                end else if (i_run && !restart_pending && space_ok && !mem.busy) begin
                    state_next = REQ;
                end
            end

            REQ: begin
                fifo_snap  = 1'b1;
                state_next = WAIT_DATA;
                // The request still goes out; its data is discarded.
                if (i_frame_start) begin
                    fifo_flush   = 1'b1;
                    pending_next = 1'b1;
                end
            end

            WAIT_DATA: begin
                if (i_frame_start) begin
                    pending_next = 1'b1;
                end
                if (mem.valid_rd) begin
                    fifo_push = !discard;
                    if (last_word) begin
                        state_next   = IDLE;
                        pending_next = 1'b0;
                        if (discard) begin
                            fifo_flush = 1'b1;
                        end else begin
                            addr_advance = 1'b1;
                        end
                    end
                end else if (wd_expired) begin
                    state_next   = IDLE;
                    pending_next = 1'b0;
                    timeout_hit  = 1'b1;
                    if (discard) begin
                        fifo_flush = 1'b1;
                    end else begin
                        fifo_rollback = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_addr      <= BaseAddr;
            word_cnt        <= '0;
            wd_cnt          <= '0;
            restart_pending <= 1'b0;
            o_underflow     <= 1'b0;
            o_timeout       <= 1'b0;
            mem_enable_q    <= 1'b0;
            mem_addr_q      <= BaseAddr;
        end else begin
            restart_pending <= pending_next;

            // Registered request: high for the single cycle after REQ.
            mem_enable_q <= (state == REQ);
            if (state == REQ) begin
                mem_addr_q <= fetch_addr;
            end

            if (state == REQ) begin
                word_cnt <= '0;
                wd_cnt   <= '0;
            end else if (state == WAIT_DATA) begin
                if (mem.valid_rd) begin
                    word_cnt <= word_cnt + WcW'(1);
                    wd_cnt   <= '0;
                end else begin
                    wd_cnt <= wd_cnt + WdW'(1);
                end
            end

            // Every flush is a frame restart; a timeout keeps the address
            // so the same burst is fetched again.
            if (fifo_flush) begin
                fetch_addr <= BaseAddr;
            end else if (addr_advance) begin
                fetch_addr <= wrapped_addr;
            end

            if (i_frame_start) begin
                o_underflow <= 1'b0;
            end else if (i_pix_ready && !o_pix_valid && i_run) begin
                o_underflow <= 1'b1;
            end

            if (timeout_hit) begin
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// ---------------------------------------------------------------------------
// tb_vga_line_fetcher
// Directed bench for vga_line_fetcher with a 32-word frame so address wrap is
// reached quickly. The controller side is driven from the stimulus sequence:
// each served burst returns words starting two cycles after the request is
// seen. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vga_line_fetcher;
    logic        clk;
    logic        rst;
    logic        run;
    logic        frame_start;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        underflow;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    vga_line_fetcher_if #(.WordLength(16), .AddressWidth(24)) mif ();

    vga_line_fetcher #(
        .WordLength    (16),
        .AddressWidth  (24),
        .BurstLength   (8),
        .FifoDepth     (32),
        .FrameBase     (0),
        .FrameWords    (32),
        .TimeoutCycles (64)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .i_run         (run),
        .i_frame_start (frame_start),
        .i_pix_ready   (pix_ready),
        .o_pix_data    (pix_data),
        .o_pix_valid   (pix_valid),
        .o_underflow   (underflow),
        .o_timeout     (timeout),
        .mem           (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for a request; returns its address.
    task automatic wait_req(output logic [23:0] addr, output logic seen);
        seen = 1'b0;
        addr = '0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (mif.enable) begin
                seen = 1'b1;
                addr = mif.addr;
            end
        end
    endtask

    // Returns n words first, first+1, ...; pulses frame_start with word fs_at.
    task automatic burst(input logic [15:0] first, input int n, input int fs_at);
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            mif.valid_rd = 1'b1;
            mif.data     = first + 16'(i);
            frame_start  = (i == fs_at);
            @(negedge clk);
        end
        mif.valid_rd = 1'b0;
        mif.data     = '0;
        frame_start  = 1'b0;
    endtask

    // Pops n words, expecting first, first+1, ... at the head.
    task automatic pop_n(input int n, input int first, input string tag);
        for (int i = 0; i < n; i++) begin
            check(tag, {15'd0, pix_valid, pix_data}, {15'd0, 1'b1, 16'(first + i)});
            pix_ready = 1'b1;
            @(negedge clk);
        end
        pix_ready = 1'b0;
    endtask

    initial begin
        logic [23:0] a;
        logic        ok;
        logic        seen;
        int          cyc;
        logic [23:0] t2_addr [4];

        t2_addr = '{24'd16, 24'd24, 24'd0, 24'd8};

        rst          = 1'b1;
        run          = 1'b0;
        frame_start  = 1'b0;
        pix_ready    = 1'b0;
        mif.busy     = 1'b0;
        mif.valid_rd = 1'b0;
        mif.data     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_underflow", underflow, 0);
        check("rst_timeout", timeout, 0);
        check("rst_mem_enable", mif.enable, 0);
        check("rst_mem_addr", mif.addr, 0);
        check("rst_mem_rw", mif.rw, 1);

        // First two bursts, then drain in order
        rst = 1'b0;
        run = 1'b1;
        wait_req(a, ok);
        check("t1_req0_seen", ok, 1);
        check("t1_req0_addr", a, 24'h000000);
        @(negedge clk);
        check("t1_enable_one_cycle", mif.enable, 0);
        burst(16'h0000, 8, -1);
        wait_req(a, ok);
        check("t1_req1_seen", ok, 1);
        check("t1_req1_addr", a, 24'h000008);
        burst(16'h0008, 8, -1);
        run = 1'b0;
        pop_n(16, 0, "t1_pop");
        check("t1_drained", pix_valid, 0);
        check("t1_no_underflow", underflow, 0);

        // Stalled consumer: four bursts fill the FIFO, wrap 24 -> 0
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(a, ok);
            check("t2_req_seen", ok, 1);
            check("t2_req_addr", a, t2_addr[i]);
            burst(t2_addr[i][15:0], 8, -1);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mif.enable) seen = 1'b1;
        end
        check("t2_no_fifth_req", seen, 0);
        pop_n(7, 16, "t2_pop");
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mif.enable) seen = 1'b1;
        end
        check("t2_no_req_after_7_pops", seen, 0);
        pop_n(1, 23, "t2_pop8");
        wait_req(a, ok);
        check("t2_req_after_space_seen", ok, 1);
        check("t2_req_after_space_addr", a, 24'h000010);
        burst(16'h0010, 8, -1);

        // Frame start while idle, then frame start in the middle of a burst
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("t4_flush_idle", pix_valid, 0);
        wait_req(a, ok);
        check("t4_req_base_addr", a, 24'h000000);
        burst(16'h0000, 8, -1);
        wait_req(a, ok);
        check("t4_req_8_addr", a, 24'h000008);
        burst(16'h0008, 8, -1);
        wait_req(a, ok);
        check("t4_req_16_addr", a, 24'h000010);
        burst(16'h0010, 8, 3);
        check("t4_flush_after_burst", pix_valid, 0);
        wait_req(a, ok);
        check("t4_restart_seen", ok, 1);
        check("t4_restart_addr", a, 24'h000000);

        // Underflow: pop attempt while empty and running
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        check("t5_underflow_set", underflow, 1);
        burst(16'h0000, 8, -1);
        check("t5_underflow_sticky", underflow, 1);

        // Watchdog: partial burst of 5 words, then silence
        wait_req(a, ok);
        check("t6_req_addr", a, 24'h000008);
        burst(16'h00A0, 5, -1);
        check("t6_no_timeout_yet", timeout, 0);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 100 && !ok) begin
            @(negedge clk);
            cyc++;
            if (timeout) ok = 1'b1;
        end
        check("t6_timeout_set", ok, 1);
        check("t6_timeout_cycles", cyc, 64);
        wait_req(a, ok);
        check("t6_retry_seen", ok, 1);
        check("t6_retry_addr", a, 24'h000008);
        burst(16'h0008, 8, -1);
        run = 1'b0;
        pop_n(16, 0, "t6_pop");
        check("t6_drained", pix_valid, 0);
        check("t6_underflow_held", underflow, 1);
        check("t6_timeout_held", timeout, 1);

        // Frame start clears underflow but not timeout
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("t7_underflow_cleared", underflow, 0);
        check("t7_timeout_kept", timeout, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: observed=running expected=finished");
        $fatal(1);
    end

endmodule
